bsg_tagged_delay_responder: RTL and testbench

- Far end of the reorder-FIFO alloc/write protocol. Accepts tagged requests (id, data) in arrival order. Holds each one in the slot indexed by its id for a per-request delay, then returns (id, data) out of order through a valid/yumi port.
- Synthesizable replacement for behavioural remote-node models. Allows deterministic, reproducible out-of-order completion in benches and in FPGA/emulation builds in front of bsg_fifo_reorder_sync.

---
 rtl/bsg_tagged_delay_responder.sv | 209 ++++++++++++++++++++
 tb/tb_bsg_tagged_delay_responder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_tagged_delay_responder.sv
// bsg_tagged_delay_responder
//
// Far end of the reorder-FIFO alloc/write protocol. Tagged requests (id, data)
// arrive in order. Each one is parked in the slot named by its id and held
// for a per-request delay. It is then returned out of order through a
// valid/yumi port. This gives deterministic, reproducible out-of-order
// completion in front of bsg_fifo_reorder_sync.
//
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   v_i, ready_o  request handshake. ready_o depends only on id_i and on the
//                 registered occupancy of that slot.
//   id_i          request slot index
//   data_i        request payload
//   delay_i       extra hold cycles beyond the 1-cycle minimum latency
//   v_o, yumi_i   response handshake. yumi_i is legal only while v_o=1.
//   id_o, data_o  response slot index and the stored payload
//   busy_o        per-slot occupancy bitmap
//
// Output selection is round-robin, starting from the slot after the last
// grant. Once a response has been presented it stays locked on that slot
// until yumi_i, so later eligible slots never preempt it.

module bsg_tagged_delay_responder #(
    parameter int width_p       = 32,
    parameter int els_p         = 16,
    parameter int delay_width_p = 6,
    parameter int lg_els_lp     = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [lg_els_lp-1:0]     id_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [delay_width_p-1:0] delay_i,

    output logic                     v_o,
    output logic [lg_els_lp-1:0]     id_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i,

    output logic [els_p-1:0]         busy_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                   state_reg, state_next;
    logic [lg_els_lp-1:0]     lock_slot_reg, lock_slot_next;
    logic [lg_els_lp-1:0]     rr_reg, rr_next;

    logic                     occupied_reg [els_p];
    logic [delay_width_p-1:0] counter_reg  [els_p];
    logic [width_p-1:0]       data_reg     [els_p];

    logic [els_p-1:0]         occupied_vec;
    logic [els_p-1:0]         eligible;
    logic [els_p-1:0]         accept_dec;
    logic [els_p-1:0]         release_dec;

    logic                     id_in_range;
    logic                     accept;
    logic                     yumi_fire;
    logic                     pick_found;
    logic [lg_els_lp-1:0]     pick_id;
    logic [lg_els_lp-1:0]     grant_id;

    // Slot index + 1, wrapping from els_p-1 back to 0. This also holds when
    // els_p is not a power of two.
    function automatic logic [lg_els_lp-1:0] next_slot(input logic [lg_els_lp-1:0] s);
        next_slot = (s == lg_els_lp'(els_p - 1)) ? '0 : s + 1'b1;
    endfunction

    // ---------------------------------------------------------------------
    // Request side
    // ---------------------------------------------------------------------
    // The range term only matters when els_p is not a power of two. It keeps
    // an out-of-range id from ever being accepted.
    assign id_in_range = (int'(id_i) < els_p);
    assign ready_o     = ~reset & id_in_range & ~occupied_vec[id_i];
    assign accept      = v_i & ready_o;

    // ---------------------------------------------------------------------
    // Per-slot storage, countdown and eligibility
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < els_p; gi++) begin : g_slot
        assign occupied_vec[gi] = occupied_reg[gi];
        assign eligible[gi]     = occupied_reg[gi] & (counter_reg[gi] == '0);
        assign accept_dec[gi]   = accept & (id_i == lg_els_lp'(gi));
        assign release_dec[gi]  = yumi_fire & (grant_id == lg_els_lp'(gi));

        // Accept and release never hit the same slot in one cycle, because
        // ready_o is low while the slot is still occupied.
        always_ff @(posedge clk) begin
            if (reset) begin
                occupied_reg[gi] <= 1'b0;
                counter_reg[gi]  <= '0;
            end else if (accept_dec[gi]) begin
                occupied_reg[gi] <= 1'b1;
                counter_reg[gi]  <= delay_i;
            end else begin
                if (release_dec[gi]) begin
                    occupied_reg[gi] <= 1'b0;
                end
                // The counter stops at zero rather than wrapping.
                if (occupied_reg[gi] && (counter_reg[gi] != '0)) begin
                    counter_reg[gi] <= counter_reg[gi] - 1'b1;
                end
            end
        end

        // The payload needs no reset. It is only observable while the slot
        // is occupied.
        always_ff @(posedge clk) begin
            if (accept_dec[gi]) begin
                data_reg[gi] <= data_i;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Round-robin pick: first eligible slot at or after rr_reg, wrapping.
    // The pick is purely combinational from registered state, so a new
    // response can be presented in the cycle right after a yumi.
    // ---------------------------------------------------------------------
    always_comb begin : rr_pick
        logic [lg_els_lp-1:0] idx;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = rr_reg;
        for (int i = 0; i < els_p; i++) begin
            if (!pick_found && eligible[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
            idx = next_slot(idx);
        end
    end

    // ---------------------------------------------------------------------
    // Output lock FSM
    // ---------------------------------------------------------------------
    assign grant_id  = (state_reg == ST_LOCKED) ? lock_slot_reg : pick_id;
    assign v_o       = ~reset & ((state_reg == ST_LOCKED) | pick_found);
    assign id_o      = grant_id;
    assign data_o    = data_reg[grant_id];
    assign yumi_fire = yumi_i & v_o;
    assign busy_o    = reset ? '0 : occupied_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            lock_slot_reg <= '0;
            rr_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            lock_slot_reg <= lock_slot_next;
            rr_reg        <= rr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        lock_slot_next = lock_slot_reg;
        rr_next        = rr_reg;

        case (state_reg)
            ST_IDLE: begin
                // A response consumed in the same cycle it first appears
                // never needs the lock.
                if (pick_found && !yumi_fire) begin
                    state_next     = ST_LOCKED;
                    lock_slot_next = pick_id;
                end
            end
            ST_LOCKED: begin
                if (yumi_fire) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (yumi_fire) begin
            rr_next = next_slot(grant_id);
        end
    end

    // ---------------------------------------------------------------------
    // Protocol checks (simulation only)
    // ---------------------------------------------------------------------
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(yumi_i && !v_o))
                else $error("bsg_tagged_delay_responder: yumi_i asserted while v_o=0");
            assert (!(v_i && !id_in_range))
                else $error("bsg_tagged_delay_responder: id_i out of range with v_i=1");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_tagged_delay_responder.sv
// Self-checking bench for bsg_tagged_delay_responder.
//
// Each cycle, a reference model predicts ready_o, v_o, id_o, data_o and busy_o.
// The model keeps each held request's absolute eligibility time (accept
// cycle + 1 + delay). It applies the round-robin rule and the hold-until-yumi
// rule directly to those times. A constant vector table and hand-written
// sequences add fixed expectations for the corner cases. A randomized run
// then covers everything else.

module tb_bsg_tagged_delay_responder;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int DW = 6;
    localparam int LG = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          v_i;
    logic          ready_o;
    logic [LG-1:0] id_i;
    logic [W-1:0]  data_i;
    logic [DW-1:0] delay_i;
    logic          v_o;
    logic [LG-1:0] id_o;
    logic [W-1:0]  data_o;
    logic          yumi_i;
    logic [N-1:0]  busy_o;

    bsg_tagged_delay_responder #(
        .width_p      (W),
        .els_p        (N),
        .delay_width_p(DW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .v_i    (v_i),
        .ready_o(ready_o),
        .id_i   (id_i),
        .data_i (data_i),
        .delay_i(delay_i),
        .v_o    (v_o),
        .id_o   (id_o),
        .data_o (data_o),
        .yumi_i (yumi_i),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          m_occ    [N];
    logic [31:0] m_data   [N];
    longint      m_elig   [N];
    bit          m_locked;
    int          m_lock_id;
    int          m_rr;
    longint      cyc;

    // Observations from the most recent step.
    bit          obs_v;
    int          obs_id;
    logic [31:0] obs_data;
    bit          obs_ready;
    logic [15:0] obs_busy;
    bit          obs_fire;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < N; s++) begin
            m_occ[s]  = 1'b0;
            m_elig[s] = 0;
        end
        m_locked  = 1'b0;
        m_lock_id = 0;
        m_rr      = 0;
    endtask

    // One clock cycle. Inputs are applied, outputs are checked against the
    // model, the model advances, and the task returns 1 time unit after the
    // next rising edge. yumi is only driven when a response is predicted.
    task automatic step(input bit rst, input bit v, input int id, input logic [31:0] data,
                        input int dly, input bit yumi);
        bit          p_ready;
        bit          p_v;
        int          p_id;
        logic [15:0] p_busy;
        p_v  = 1'b0;
        p_id = 0;
        if (!rst) begin
            if (m_locked) begin
                p_v  = 1'b1;
                p_id = m_lock_id;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int s;
                    s = (m_rr + k) % N;
                    if (!p_v && m_occ[s] && cyc >= m_elig[s]) begin
                        p_v  = 1'b1;
                        p_id = s;
                    end
                end
            end
        end
        p_ready = !rst && !m_occ[id];
        for (int s = 0; s < N; s++) p_busy[s] = !rst && m_occ[s];

        reset   = rst;
        v_i     = v;
        id_i    = id[LG-1:0];
        data_i  = data;
        delay_i = dly[DW-1:0];
        yumi_i  = yumi && p_v;
        #1;
        obs_v     = v_o;
        obs_id    = int'(id_o);
        obs_data  = data_o;
        obs_ready = ready_o;
        obs_busy  = busy_o;
        obs_fire  = yumi_i;

        chk("ready_o", ready_o, p_ready);
        chk("v_o", v_o, p_v);
        if (p_v) begin
            chk("id_o", id_o, p_id);
            chk("data_o", data_o, m_data[p_id]);
        end
        chk("busy_o", busy_o, p_busy);
        if (yumi_i) $display("resp id=%0d data=%08h cycle=%0d", id_o, data_o, cyc);

        if (rst) begin
            model_reset();
        end else begin
            if (yumi_i) begin
                m_occ[p_id] = 1'b0;
                m_locked    = 1'b0;
                m_rr        = (p_id + 1) % N;
            end else if (p_v) begin
                m_locked  = 1'b1;
                m_lock_id = p_id;
            end
            if (v && p_ready) begin
                m_occ[id]  = 1'b1;
                m_data[id] = data;
                m_elig[id] = cyc + 1 + dly;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        bit          v;
        int          id;
        logic [31:0] data;
        int          dly;
        bit          yumi;
        bit          e_ready;
        bit          e_v;
        int          e_id;
        logic [31:0] e_data;
        logic [15:0] e_busy;
    } vec_t;

    vec_t tbl[12];

    int     got_id[$];
    longint got_off[$];
    longint t0;
    int     vcount;

    initial begin
        reset   = 1'b1;
        v_i     = 1'b0;
        id_i    = '0;
        data_i  = '0;
        delay_i = '0;
        yumi_i  = 1'b0;
        cyc     = 0;
        model_reset();
        for (int s = 0; s < N; s++) m_data[s] = '0;

        // Single request, slot collision, and accept/yumi on different slots.
        // Starts from a freshly reset, empty responder.
        tbl[0]  = '{1, 3, 32'hA5A5_0003, 0, 0,  1, 0, 0, 32'h0,          16'h0000};
        tbl[1]  = '{0, 0, 32'h0,         0, 1,  1, 1, 3, 32'hA5A5_0003,  16'h0008};
        tbl[2]  = '{1, 5, 32'h0000_0055, 0, 0,  1, 0, 0, 32'h0,          16'h0000};
        tbl[3]  = '{1, 5, 32'h0000_0066, 0, 0,  0, 1, 5, 32'h0000_0055,  16'h0020};
        tbl[4]  = '{1, 5, 32'h0000_0077, 0, 1,  0, 1, 5, 32'h0000_0055,  16'h0020};
        tbl[5]  = '{1, 5, 32'h0000_0088, 0, 0,  1, 0, 0, 32'h0,          16'h0000};
        tbl[6]  = '{0, 0, 32'h0,         0, 1,  1, 1, 5, 32'h0000_0088,  16'h0020};
        tbl[7]  = '{1, 2, 32'h0000_0022, 0, 0,  1, 0, 0, 32'h0,          16'h0000};
        tbl[8]  = '{1, 9, 32'h0000_0099, 1, 1,  1, 1, 2, 32'h0000_0022,  16'h0004};
        tbl[9]  = '{0, 0, 32'h0,         0, 0,  1, 0, 0, 32'h0,          16'h0200};
        tbl[10] = '{0, 0, 32'h0,         0, 1,  1, 1, 9, 32'h0000_0099,  16'h0200};
        tbl[11] = '{0, 0, 32'h0,         0, 0,  1, 0, 0, 32'h0,          16'h0000};

        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            step(0, tbl[i].v, tbl[i].id, tbl[i].data, tbl[i].dly, tbl[i].yumi);
            chk($sformatf("tbl%0d_ready", i), obs_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_v", i), obs_v, tbl[i].e_v);
            if (tbl[i].e_v) begin
                chk($sformatf("tbl%0d_id", i), obs_id, tbl[i].e_id);
                chk($sformatf("tbl%0d_data", i), obs_data, tbl[i].e_data);
            end
            chk($sformatf("tbl%0d_busy", i), obs_busy, tbl[i].e_busy);
        end

        // Reordering: delays 10, 2, 5 on consecutive cycles. The responses
        // come back as id1, id2, id0 at offsets 4, 8, 11 with yumi held high.
        got_id.delete();
        got_off.delete();
        t0 = cyc;
        for (int i = 0; i < 18; i++) begin
            longint c;
            c = cyc;
            if (i == 0)      step(0, 1, 0, 32'h100, 10, 1);
            else if (i == 1) step(0, 1, 1, 32'h101, 2, 1);
            else if (i == 2) step(0, 1, 2, 32'h102, 5, 1);
            else             step(0, 0, 0, 0, 0, 1);
            if (obs_fire) begin
                got_id.push_back(obs_id);
                got_off.push_back(c - t0);
            end
        end
        chk("reorder_count", got_id.size(), 3);
        if (got_id.size() >= 3) begin
            chk("reorder_id0", got_id[0], 1);
            chk("reorder_off0", got_off[0], 4);
            chk("reorder_id1", got_id[1], 2);
            chk("reorder_off1", got_off[1], 8);
            chk("reorder_id2", got_id[2], 0);
            chk("reorder_off2", got_off[2], 11);
        end

        // Fill all 16 slots with delay 0 and yumi tied to v_o. Ids return
        // in order, one per cycle.
        got_id.delete();
        got_off.delete();
        t0 = cyc;
        for (int i = 0; i < 19; i++) begin
            longint c;
            c = cyc;
            if (i < N) step(0, 1, i, 32'h200 + 32'(i), 0, 1);
            else       step(0, 0, 0, 0, 0, 1);
            if (obs_fire) begin
                got_id.push_back(obs_id);
                got_off.push_back(c - t0);
            end
        end
        chk("fill_count", got_id.size(), N);
        for (int i = 0; i < N; i++) begin
            if (i < got_id.size()) begin
                chk($sformatf("fill_id%0d", i), got_id[i], i);
                chk($sformatf("fill_off%0d", i), got_off[i], i + 1);
            end
        end

        // Lock: id7 is presented first. id3 becomes eligible while yumi is
        // held low, but it must not preempt id7. After id7 is consumed, the
        // pointer wraps past 15 and reaches id3.
        step(0, 1, 7, 32'h307, 0, 0);
        step(0, 1, 3, 32'h303, 2, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk("lock_v", obs_v, 1);
            chk("lock_id", obs_id, 7);
            chk("lock_data", obs_data, 32'h307);
        end
        step(0, 0, 0, 0, 0, 1);
        chk("lock_release_id", obs_id, 7);
        step(0, 0, 0, 0, 0, 1);
        chk("after_wrap_id", obs_id, 3);
        chk("after_wrap_data", obs_data, 32'h303);
        step(0, 0, 0, 0, 0, 0);

        // Reset mid-operation with six slots busy.
        for (int k = 10; k < 16; k++) step(0, 1, k, 32'h400 + 32'(k), 20, 0);
        chk("pre_reset_busy", obs_busy, 16'h7C00);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_busy", obs_busy, 16'h0000);
        chk("rst_v", obs_v, 0);
        chk("rst_ready", obs_ready, 0);
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (obs_v) vcount++;
        end
        chk("no_stale_resp", vcount, 0);

        // Randomized traffic, with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            bit          rv;
            int          rid;
            logic [31:0] rdata;
            int          rdly;
            bit          ry;
            rv    = 1'($urandom_range(0, 1));
            rid   = int'($urandom_range(0, N - 1));
            rdata = $urandom;
            rdly  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                                : int'($urandom_range(0, 4));
            ry    = ($urandom_range(0, 3) != 0);
            step(i == 1500, rv, rid, rdata, rdly, ry);
        end

        // Drain, bounded by a cycle budget.
        for (int i = 0; i < 200; i++) begin
            bit any;
            any = m_locked;
            for (int s = 0; s < N; s++) if (m_occ[s]) any = 1'b1;
            if (!any) break;
            step(0, 0, 0, 0, 0, 1);
        end
        #1;
        chk("drain_busy", busy_o, 16'h0000);
        chk("drain_v", v_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
